// File: rtl/exp2_seq.sv
// -----------------------------------------------------------------------------
// exp2_seq: sequential power-of-two decoder (inverse of floor-log2).
//
// An exponent e arrives on a valid/ready handshake. The block returns the
// one-hot value 2^e on a second valid/ready handshake. If e >= WIDTH it returns
// zero and raises ovf_o. The default build is an iterative shifter that moves
// one bit position per clock.
//
// Optional build macro:
//   EXP2_SEQ_FAST_EN - when defined, the SHIFT state and its counter are
//                      removed and the result is decoded in one step. The
//                      latency is then 1 cycle for every exponent. The
//                      handshake behaviour does not change.
//
// Ports:
//   clk_i    in   1      clock; all state changes on the rising edge
//   rst_i    in   1      asynchronous reset, active-high
//   a_i      in   EXP_W  exponent, sampled only on the accepting edge
//   valid_i  in   1      requester has a valid exponent
//   ready_o  out  1      block can accept an exponent (state IDLE)
//   y_o      out  WIDTH  2^a_i, or zero on overflow
//   ovf_o    out  1      sampled a_i >= WIDTH
//   valid_o  out  1      y_o/ovf_o hold a result
//   ready_i  in   1      consumer accepts the result
//   busy_o   out  1      state is SHIFT or DONE
// -----------------------------------------------------------------------------
module exp2_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned EXP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [EXP_W-1:0] a_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o
);

  // Overflow is only reachable if WIDTH fits in the exponent field.
  localparam bit               OvfReach = ($clog2(WIDTH + 1) <= EXP_W);
  localparam logic [EXP_W-1:0] WidthE   = EXP_W'(WIDTH);

`ifdef EXP2_SEQ_FAST_EN
  typedef enum logic [1:0] {StIdle, StDone} state_t;
`else
  // Counter only needs to hold 0..WIDTH-1.
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_ovf;
  logic             r_valid;
  logic             r_busy;
  logic             r_ready;
  logic             w_ovf;

  assign w_ovf = OvfReach && (a_i >= WidthE);

`ifdef EXP2_SEQ_FAST_EN
  logic [WIDTH-1:0] w_onehot;
  // Only used when w_ovf is low, so a_i < WIDTH and the shift stays in range.
  assign w_onehot = WIDTH'(1) << a_i;
`else
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_a_cnt;
  logic            w_a_zero;
  assign w_a_cnt  = CntW'(a_i);
  assign w_a_zero = (a_i == '0);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
`ifndef EXP2_SEQ_FAST_EN
      r_cnt   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (valid_i) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_ovf) begin
              r_y     <= '0;
              r_ovf   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= StDone;
            end
`ifdef EXP2_SEQ_FAST_EN
            else begin
              r_y     <= w_onehot;
              r_ovf   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= StDone;
            end
`else
            else if (w_a_zero) begin
              r_y     <= WIDTH'(1);
              r_ovf   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= StDone;
            end else begin
              r_y     <= WIDTH'(1);
              r_ovf   <= 1'b0;
              r_cnt   <= w_a_cnt;
              r_state <= StShift;
            end
`endif
          end
        end

`ifndef EXP2_SEQ_FAST_EN
        // r_cnt never exceeds WIDTH-1, so the one bit cannot shift out of range.
        StShift: begin
          r_y   <= r_y << 1;
          r_cnt <= r_cnt - CntW'(1);
          if (r_cnt == CntW'(1)) begin
            r_valid <= 1'b1;
            r_state <= StDone;
          end
        end
`endif

        // ready_o stays low on the release edge. This guarantees one IDLE cycle
        // between results.
        StDone: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= StIdle;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign y_o     = r_y;
  assign ovf_o   = r_ovf;
  assign valid_o = r_valid;
  assign busy_o  = r_busy;

endmodule
